// File: rtl/fifo_flow_ctrl.sv
// Parametrised synchronous FIFO with hysteretic PAUSE/CONTINUE flow control.
// Define FIFO_ERR_STICKY_EN to make error sticky until reset (default: one-cycle pulse).
module fifo_flow_ctrl #(
  parameter int DATA_W      = 6,
  parameter int DEPTH       = 8,
  parameter int PAUSE_TH    = 6,
  parameter int CONTINUE_TH = 2,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              valid,
  input  logic [DATA_W-1:0] Fifo_Data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] Fifo_data_out,
  output logic              valid_out,
  output logic              Fifo_empty,
  output logic              Fifo_full,
  output logic [CNT_W-1:0]  count,
  output logic              PAUSE,
  output logic              CONTINUE,
  output logic              error
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {RUN, HOLD} fc_state_t;

  fc_state_t          state;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               wr_en;
  logic               rd_en;
  logic               err_now;
  logic [CNT_W-1:0]   next_count;

  // Status flags decode the registered count, so they stay free of input paths.
  assign Fifo_empty = (count == '0);
  assign Fifo_full  = (count == CNT_W'(DEPTH));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_en      = pop && !Fifo_empty;
    wr_en      = push && valid && (!Fifo_full || rd_en);
    next_count = count;
    if (wr_en && !rd_en)
      next_count = count + CNT_W'(1);
    else if (rd_en && !wr_en)
      next_count = count - CNT_W'(1);
    err_now = (push && valid && Fifo_full && !pop) || (pop && Fifo_empty);
  end

  // NOTE: storage has no reset; stale words are never readable because count gates rd_en.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= Fifo_Data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      Fifo_data_out <= '0;
      valid_out     <= 1'b0;
    end else begin
      count     <= next_count;
      valid_out <= rd_en;
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) begin
        Fifo_data_out <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Hysteresis: enter HOLD at the high mark, leave only at the low mark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      PAUSE    <= 1'b0;
      CONTINUE <= 1'b0;
    end else begin
      CONTINUE <= 1'b0;
      case (state)
        RUN: begin
          if (next_count >= CNT_W'(PAUSE_TH)) begin
            state <= HOLD;
            PAUSE <= 1'b1;
          end
        end
        HOLD: begin
          if (next_count <= CNT_W'(CONTINUE_TH)) begin
            state    <= RUN;
            PAUSE    <= 1'b0;
            CONTINUE <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          PAUSE <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      error <= 1'b0;
    else
`ifdef FIFO_ERR_STICKY_EN
      error <= error || err_now;
`else
      error <= err_now;
`endif
  end

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Self-checking bench for fifo_flow_ctrl: queue-based reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_fifo_flow_ctrl;

  localparam int DATA_W      = 6;
  localparam int DEPTH       = 8;
  localparam int PAUSE_TH    = 6;
  localparam int CONTINUE_TH = 2;
  localparam int CNT_W       = $clog2(DEPTH + 1);
`ifdef FIFO_ERR_STICKY_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              push;
  logic              valid;
  logic [DATA_W-1:0] din;
  logic              pop;
  logic [DATA_W-1:0] dout;
  logic              vout;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              pause;
  logic              cont;
  logic              err;

  int checks   = 0;
  int failures = 0;

  fifo_flow_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PAUSE_TH(PAUSE_TH), .CONTINUE_TH(CONTINUE_TH)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .valid(valid), .Fifo_Data_in(din),
    .pop(pop), .Fifo_data_out(dout), .valid_out(vout), .Fifo_empty(empty),
    .Fifo_full(full), .count(count), .PAUSE(pause), .CONTINUE(cont), .error(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue holding the FIFO contents, updated from the rules.
  logic [DATA_W-1:0] q[$];
  int                m_count = 0;
  logic [DATA_W-1:0] m_dout  = '0;
  logic              m_vout  = 1'b0;
  logic              m_pause = 1'b0;
  logic              m_cont  = 1'b0;
  logic              m_err   = 1'b0;

  always @(posedge clk or posedge reset) begin : model
    int old_n;
    int new_n;
    logic rd, wr, ov, un;
    logic [DATA_W-1:0] rdata;
    if (reset) begin
      q.delete();
      m_count <= 0;
      m_dout  <= '0;
      m_vout  <= 1'b0;
      m_pause <= 1'b0;
      m_cont  <= 1'b0;
      m_err   <= 1'b0;
    end else begin
      old_n = q.size();
      rd    = pop && (old_n > 0);
      wr    = push && valid && ((old_n < DEPTH) || rd);
      ov    = push && valid && (old_n == DEPTH) && !pop;
      un    = pop && (old_n == 0);
      if (rd) begin
        rdata = q.pop_front();
        m_dout <= rdata;
      end
      m_vout <= rd;
      if (wr) q.push_back(din);
      new_n = q.size();
      m_count <= new_n;
      m_cont  <= 1'b0;
      if (!m_pause && new_n >= PAUSE_TH)
        m_pause <= 1'b1;
      else if (m_pause && new_n <= CONTINUE_TH) begin
        m_pause <= 1'b0;
        m_cont  <= 1'b1;
      end
      m_err <= STICKY ? (m_err || ov || un) : (ov || un);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_count", 32'(count), 32'(m_count));
    check("cmp_empty", 32'(empty), 32'(m_count == 0));
    check("cmp_full",  32'(full),  32'(m_count == DEPTH));
    check("cmp_vout",  32'(vout),  32'(m_vout));
    check("cmp_dout",  32'(dout),  32'(m_dout));
    check("cmp_pause", 32'(pause), 32'(m_pause));
    check("cmp_cont",  32'(cont),  32'(m_cont));
    check("cmp_err",   32'(err),   32'(m_err));
  end

  task automatic step(input logic p, input logic v, input logic [DATA_W-1:0] d, input logic o);
    @(negedge clk);
    push  = p;
    valid = v;
    din   = d;
    pop   = o;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"},  32'(full),  0);
    check({tag, "_dout"},  32'(dout),  0);
    check({tag, "_vout"},  32'(vout),  0);
    check({tag, "_pause"}, 32'(pause), 0);
    check({tag, "_cont"},  32'(cont),  0);
    check({tag, "_err"},   32'(err),   0);
  endtask

  initial begin
    reset = 1'b1;
    push  = 1'b0;
    valid = 1'b0;
    din   = '0;
    pop   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    reset = 1'b0;

    // Fill with 0x01..0x08, then drain in order.
    for (int i = 1; i <= 8; i++) step(1, 1, DATA_W'(i), 0);
    check("fill_full",  32'(full),  1);
    check("fill_count", 32'(count), 8);
    check("fill_pause", 32'(pause), 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, '0, 1);
      check("drain_dout", 32'(dout), 32'(i));
      check("drain_vout", 32'(vout), 1);
    end
    check("drain_empty", 32'(empty), 1);
    step(0, 0, '0, 0);

    // Hysteresis between the thresholds.
    for (int i = 0; i < 6; i++) step(1, 1, DATA_W'(8'h10 + i), 0);
    check("hys_pause_on", 32'(pause), 1);
    for (int i = 0; i < 3; i++) step(0, 0, '0, 1);
    check("hys_cnt3",       32'(count), 3);
    check("hys_pause_hold", 32'(pause), 1);
    check("hys_cont_low",   32'(cont),  0);
    step(0, 0, '0, 1);
    check("hys_cnt2",      32'(count), 2);
    check("hys_pause_off", 32'(pause), 0);
    check("hys_cont_1",    32'(cont),  1);
    step(0, 0, '0, 0);
    check("hys_cont_done", 32'(cont), 0);
    for (int i = 0; i < 2; i++) step(0, 0, '0, 1);

    // Wrap-around at a steady occupancy of 4.
    for (int i = 0; i < 4; i++) step(1, 1, DATA_W'(8'h30 + i), 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 1, DATA_W'(i), 1);
      check("wrap_dout",  32'(dout),  (i < 4) ? 32'(8'h30 + i) : 32'(i - 4));
      check("wrap_count", 32'(count), 4);
    end
    for (int i = 16; i < 20; i++) begin
      step(0, 0, '0, 1);
      check("wrap_tail", 32'(dout), 32'(i));
    end

    // Full boundary: simultaneous push+pop accepted, lone push overflows.
    for (int i = 0; i < 8; i++) step(1, 1, DATA_W'(8'h20 + i), 0);
    step(1, 1, 6'h28, 1);
    check("full_pp_count", 32'(count), 8);
    check("full_pp_err",   32'(err),   0);
    check("full_pp_dout",  32'(dout),  32'h20);
    step(1, 1, 6'h3F, 0);
    check("ovf_err",   32'(err),   1);
    check("ovf_count", 32'(count), 8);
    step(0, 0, '0, 0);
    check("ovf_err_after", 32'(err), 32'(STICKY));
    for (int i = 1; i <= 8; i++) begin
      step(0, 0, '0, 1);
      check("ovf_drain", 32'(dout), 32'(8'h20 + i));
    end
    check("ovf_empty", 32'(empty), 1);

    // Empty boundary.
    step(0, 0, '0, 1);
    check("unf_err",  32'(err),  1);
    check("unf_vout", 32'(vout), 0);
    step(1, 1, 6'h15, 1);
    check("emp_pp_count", 32'(count), 1);
    check("emp_pp_vout",  32'(vout),  0);
    check("emp_pp_err",   32'(err),   1);
    step(0, 0, '0, 1);
    check("emp_pp_dout", 32'(dout), 32'h15);
    check("emp_pp_vout2", 32'(vout), 1);
    check("emp_pp_err2", 32'(err), 32'(STICKY));
    step(1, 0, 6'h2E, 0);
    check("novalid_count", 32'(count), 0);
    check("novalid_empty", 32'(empty), 1);
    check("novalid_err",   32'(err),   32'(STICKY));

    // Asynchronous reset mid-stream at count 5.
    for (int i = 1; i <= 5; i++) step(1, 1, DATA_W'(i), 0);
    check("pre_rst_count", 32'(count), 5);
    check("pre_rst_pause", 32'(pause), 0);
    step(0, 0, '0, 1);
    check("pre_rst_vout", 32'(vout), 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("arst");
    @(negedge clk);
    reset = 1'b0;
    step(1, 1, 6'h2A, 0);
    check("post_rst_count", 32'(count), 1);
    step(0, 0, '0, 1);
    check("post_rst_dout",  32'(dout),  32'h2A);
    check("post_rst_vout",  32'(vout),  1);
    check("post_rst_empty", 32'(empty), 1);
    step(0, 0, '0, 0);

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_flow_ctrl.md
# fifo_flow_ctrl

Parametrised synchronous FIFO with hysteretic PAUSE/CONTINUE flow control, the next-generation replacement for the fixed 6-bit FIFO in the datapath. It buffers qualified words between a producer and a consumer. It exports occupancy, full/empty status and protocol-error reporting. Width, depth and both flow-control thresholds are set by parameters.

## Interface
- DATA_W, 6: word width in bits.
- DEPTH, 8: number of entries. Must be a power of two, at least 2.
- PAUSE_TH, 6: occupancy at or above which PAUSE is raised. Requires CONTINUE_TH < PAUSE_TH ≤ DEPTH.
- CONTINUE_TH, 2: occupancy at or below which PAUSE is released. Requires 0 ≤ CONTINUE_TH.
- CNT_W, $clog2(DEPTH+1): occupancy width. Derived; not for override.

- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  write request.
- valid  in  1  qualifies Fifo_Data_in. A write needs push && valid.
- Fifo_Data_in  in  DATA_W  write data.
- pop  in  1  read request.
- Fifo_data_out  out  DATA_W  registered read data.
- valid_out  out  1  Fifo_data_out holds a newly popped word this cycle.
- Fifo_empty  out  1  occupancy == 0.
- Fifo_full  out  1  occupancy == DEPTH.
- count  out  CNT_W  current occupancy.
- PAUSE  out  1  back-pressure request to the producer.
- CONTINUE  out  1  one-cycle pulse when PAUSE releases.
- error  out  1  overflow or underflow indication.

## Operation
- Storage is a DEPTH×DATA_W register array with wr_ptr/rd_ptr of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH naturally.
- Write accept: wr_en = push && valid && (!Fifo_full || rd_en).
  - A write to a full FIFO is accepted when a read occurs in the same cycle.
- Read accept: rd_en = pop && !Fifo_empty. A pop on an empty FIFO is never serviced, even with a simultaneous push.
- count update per cycle:
  - +1 on wr_en only.
  - −1 on rd_en only.
  - Unchanged when both or neither occur.
  - Fifo_empty and Fifo_full are decoded from the registered count.
- Read data: on rd_en, Fifo_data_out ← mem[rd_ptr] and valid_out ← 1. Otherwise valid_out ← 0 and Fifo_data_out holds its last value.
- Flow-control state machine, evaluated on next_count:
  - States are RUN (PAUSE=0) and HOLD (PAUSE=1).
  - RUN→HOLD when next_count ≥ PAUSE_TH.
  - HOLD→RUN when next_count ≤ CONTINUE_TH. CONTINUE pulses high for exactly the one cycle in which this transition is registered.
  - Between the thresholds the state holds (hysteresis).
- Error conditions:
  - Overflow: push && valid && Fifo_full && !pop. The data is dropped and the FIFO is unchanged.
  - Underflow: pop && Fifo_empty.
- push with valid=0 is ignored silently and is not an error.

## Timing
- Reset values while reset is high:
  - wr_ptr, rd_ptr and count are 0.
  - Fifo_empty=1, Fifo_full=0.
  - Fifo_data_out=0, valid_out=0.
  - PAUSE=0, CONTINUE=0, error=0.
  - Memory contents are not reset.
- Reset asserted mid-operation clears all of the above immediately (asynchronously). Data in flight is discarded.
- Read latency: pop sampled at edge N makes data and valid_out visible after edge N, for one cycle.
- Write-to-read: a word pushed at edge N clears Fifo_empty after edge N. The earliest successful pop is sampled at edge N+1.
- count, Fifo_full, Fifo_empty, PAUSE, CONTINUE and error are all registered. Each reflects the cycle's accepted operations after the same edge.
- There is no combinational path from any input to any output.

## Configuration
- FIFO_ERR_STICKY_EN defined: error is sticky. It sets on the first overflow or underflow and clears only on reset.
- Without the macro: error is a single-cycle pulse, registered in the cycle after each offending request, and reasserts on every offending cycle.
- Port list is identical in both builds.

## Test plan
All scenarios use the defaults (DATA_W=6, DEPTH=8, PAUSE_TH=6, CONTINUE_TH=2).
- Reset then push 0x01..0x08 at one word per cycle, then pop 8 times:
  - Fifo_full=1 after the 8th write.
  - Pops return 0x01..0x08 in order, each with valid_out=1.
  - Fifo_empty=1 after the last pop.
- Hysteresis: push 6 words → PAUSE=1 after the 6th. Pop to count 3 → PAUSE stays 1. Pop to count 2 → PAUSE=0 and CONTINUE=1 for exactly one cycle.
- Wrap-around: run 20 interleaved push/pop cycles at count 4 with data = cycle index. Output order matches input and count stays at 4.
- Full boundary:
  - With count=8, push+pop in the same cycle: both accepted, count stays 8, error=0.
  - Push alone: data dropped, error asserts (pulse without the macro, sticky with it).
- Empty boundary:
  - pop on empty → error, valid_out=0.
  - Push+pop on empty in one cycle → write accepted, count=1, valid_out=0.
  - push=1 with valid=0 → nothing stored, no error.
- Asynchronous reset at count=5 with PAUSE=0 mid-stream: all outputs return to their reset values without a clock edge, and the next push/pop sequence restarts from an empty FIFO.
